// File: rtl/broadcaster.sv
// Expands two scalar pins into two N-bit adder operands plus carry-in.
// All outputs are registered: one clock of latency, synchronous active-low reset.
module broadcaster #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pin_a,
  input  logic         pin_b,
  input  logic         en,
  input  logic [1:0]   mode,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic         cin
);

  // Builds one operand from a single pin bit.
  // Checkerboard mode starts with x at bit 0 and inverts on every odd bit.
  function automatic logic [N-1:0] pattern(input logic x, input logic [1:0] m);
    logic [N-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) begin
      case (m)
        2'd0:    p[i] = x;
        2'd1:    p[i] = x ^ i[0];
        2'd2:    p[i] = (i == 0) ? x : 1'b0;
        default: p[i] = ~x;
      endcase
    end
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a   <= '0;
      b   <= '0;
      cin <= 1'b0;
    end else if (en) begin
      a   <= pattern(pin_a, mode);
      b   <= pattern(pin_b, mode);
      cin <= pin_a & pin_b;
    end
  end

endmodule

// File: tb/tb_broadcaster.sv
// Scoreboard bench for broadcaster: expected outputs are queued when inputs
// are driven and compared one clock later.
module tb_broadcaster;

  localparam int N = 16;

  logic         clk;
  logic         rst_n;
  logic         pin_a;
  logic         pin_b;
  logic         en;
  logic [1:0]   mode;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    string        tag;
  } exp_t;

  exp_t exp_q[$];

  int compared   = 0;
  int mismatched = 0;

  logic [N-1:0] model_a;
  logic [N-1:0] model_b;
  logic         model_cin;

  broadcaster #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pin_a(pin_a),
    .pin_b(pin_b),
    .en   (en),
    .mode (mode),
    .a    (a),
    .b    (b),
    .cin  (cin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single point of comparison; every check goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Reference patterns written directly as 16-bit constants.
  function automatic logic [N-1:0] ref_pattern(input logic x, input logic [1:0] m);
    case (m)
      2'd0:    return x ? 16'hFFFF : 16'h0000;
      2'd1:    return x ? 16'h5555 : 16'hAAAA;
      2'd2:    return x ? 16'h0001 : 16'h0000;
      default: return x ? 16'h0000 : 16'hFFFF;
    endcase
  endfunction

  // Drives one cycle of inputs on the falling edge and queues the expected result.
  task automatic applyStimulus(input logic r, input logic pa, input logic pb,
                               input logic e, input logic [1:0] m, input string tag);
    exp_t item;
    @(negedge clk);
    rst_n = r;
    pin_a = pa;
    pin_b = pb;
    en    = e;
    mode  = m;
    if (!r) begin
      model_a   = '0;
      model_b   = '0;
      model_cin = 1'b0;
    end else if (e) begin
      model_a   = ref_pattern(pa, m);
      model_b   = ref_pattern(pb, m);
      model_cin = pa & pb;
    end
    item.a   = model_a;
    item.b   = model_b;
    item.cin = model_cin;
    item.tag = tag;
    exp_q.push_back(item);
  endtask

  // Compare just after each rising edge, away from the update itself.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t item;
      item = exp_q.pop_front();
      checkOutput({item.tag, ".a"},   32'(a),   32'(item.a));
      checkOutput({item.tag, ".b"},   32'(b),   32'(item.b));
      checkOutput({item.tag, ".cin"}, 32'(cin), 32'(item.cin));
    end
  end

  initial begin
    rst_n = 1'b0;
    pin_a = 1'b1;
    pin_b = 1'b1;
    en    = 1'b1;
    mode  = 2'd0;
    model_a   = '0;
    model_b   = '0;
    model_cin = 1'b0;

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, "reset0");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, "reset1");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, "release");

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, "rep01");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, "rep10");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, "checker");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2'd2, "lsb");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2'd3, "inv");

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, "hold_load");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'd1, "hold0");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2'd2, "hold1");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, "hold2");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2'd1, "reenable");

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, "pre_rst");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, "mid_rst");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, "post_rst_hold");

    for (int i = 0; i < 60; i++) begin
      applyStimulus(($urandom_range(9) != 0), 1'($urandom), 1'($urandom),
                    1'($urandom), 2'($urandom), "random");
    end

    // Let the last queued entry be consumed, then confirm nothing is left over.
    @(negedge clk);
    @(negedge clk);
    checkOutput("drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
